// File: rtl/mac_sched.sv
// mac_sched: backscatter MAC scheduler. Accepts addressed downlink commands,
// waits a randomised slotted backoff, sends a head preamble followed by the
// latched scheme word MSB first, then listens for an ack. A missing ack
// triggers a retry with a binary-exponentially growing backoff window.
module mac_sched #(
  parameter int                SCHEME_W  = 48,
  parameter int                FLAG_W    = 8,
  parameter logic [FLAG_W-1:0] MY_FLAG   = 8'h01,
  parameter int                RAND_W    = 24,
  parameter int                SLOT_W    = 4,
  parameter int                SLOT_LEN  = 1024,
  parameter int                HEAD_LEN  = 16,
  parameter int                BIT_LEN   = 64,
  parameter int                ACK_TO    = 4096,
  parameter int                MAX_RETRY = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           frame_valid,
  input  logic [1:0]                     ord,
  input  logic [FLAG_W-1:0]              cur_flag,
  input  logic [SCHEME_W-1:0]            cur_scheme,
  input  logic [RAND_W-1:0]              cur_rand,
  output logic                           sending,
  output logic                           head,
  output logic                           datacmd,
  output logic                           working,
  output logic                           done,
  output logic                           fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int RTY_W       = $clog2(MAX_RETRY + 1);
  localparam int BACKOFF_MAX = SLOT_LEN * ((1 << SLOT_W) - 1);
  localparam int MAX_A       = (BACKOFF_MAX > ACK_TO) ? BACKOFF_MAX : ACK_TO;
  localparam int MAX_B       = (HEAD_LEN > BIT_LEN) ? HEAD_LEN : BIT_LEN;
  localparam int CNT_MAX     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int BIT_W       = (SCHEME_W > 1) ? $clog2(SCHEME_W) : 1;

  localparam logic [CNT_W-1:0] HEAD_LOAD = CNT_W'(HEAD_LEN - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_LEN - 1);
  localparam logic [CNT_W-1:0] ACK_LOAD  = CNT_W'(ACK_TO - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SCHEME_W - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BACKOFF  = 3'd1,
    S_HEAD     = 3'd2,
    S_DATA     = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [RTY_W-1:0]     retry_reg, retry_next;
  logic [SCHEME_W-1:0]  scheme_reg, scheme_next;
  logic [SCHEME_W-1:0]  shift_reg, shift_next;

  logic sending_reg, sending_next;
  logic head_reg, head_next;
  logic datacmd_reg, datacmd_next;
  logic working_reg, working_next;
  logic done_reg, done_next;
  logic fail_reg, fail_next;

  // Command decode: own address or broadcast (all ones)
  logic addr_match, query_hit, ack_hit, stop_hit;
  assign addr_match = frame_valid && ((cur_flag == MY_FLAG) || (&cur_flag));
  assign query_hit  = addr_match && (ord == 2'd1);
  assign ack_hit    = addr_match && (ord == 2'd2);
  assign stop_hit   = addr_match && (ord == 2'd3);

  // Attempt index the next backoff is drawn for: 0 on a fresh query,
  // retry_cnt+1 when a timeout schedules a retransmission.
  logic [RTY_W:0]      win_retry;
  logic [SLOT_W-1:0]   slot_mask;
  logic [SLOT_W-1:0]   slots;
  logic [CNT_W-1:0]    backoff_load;

  assign win_retry = (state_reg == S_WAIT_ACK) ? ({1'b0, retry_reg} + (RTY_W+1)'(1))
                                               : '0;

  genvar gi;
  generate
    for (gi = 0; gi < SLOT_W; gi++) begin : g_mask
      // Window has min(1+attempt, SLOT_W) bits, so bit gi opens once attempt >= gi
      assign slot_mask[gi] = (32'(win_retry) >= 32'(gi));
    end
    if (RAND_W > SLOT_W) begin : g_unused
      logic unused_rand;
      assign unused_rand = ^cur_rand[RAND_W-1:SLOT_W];
    end
  endgenerate

  assign slots        = cur_rand[SLOT_W-1:0] & slot_mask;
  // Counter runs load..0 inclusive, so load is one less than the cycle count
  assign backoff_load = CNT_W'(slots) * CNT_W'(SLOT_LEN) - CNT_W'(1);

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      retry_reg  <= '0;
      scheme_reg <= '0;
      shift_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      retry_reg  <= retry_next;
      scheme_reg <= scheme_next;
      shift_reg  <= shift_next;
    end
  end

  // Next-state and counter logic; stop overrides everything else
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    retry_next  = retry_reg;
    scheme_next = scheme_reg;
    shift_next  = shift_reg;
    if (stop_hit) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      bit_next   = '0;
      retry_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (query_hit) begin
            scheme_next = cur_scheme;
            shift_next  = cur_scheme;
            retry_next  = '0;
            bit_next    = '0;
            if (slots == '0) begin
              state_next = S_HEAD;
              cnt_next   = HEAD_LOAD;
            end else begin
              state_next = S_BACKOFF;
              cnt_next   = backoff_load;
            end
          end
        end
        S_BACKOFF: begin
          if (cnt_reg == '0) begin
            state_next = S_HEAD;
            cnt_next   = HEAD_LOAD;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        S_HEAD: begin
          if (cnt_reg == '0) begin
            state_next = S_DATA;
            cnt_next   = BIT_LOAD;
            bit_next   = '0;
            // Retries resend the latched word, so restore the shifter here
            shift_next = scheme_reg;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_reg == '0) begin
            if (bit_reg == LAST_BIT) begin
              state_next = S_WAIT_ACK;
              cnt_next   = ACK_LOAD;
              bit_next   = '0;
            end else begin
              shift_next = {shift_reg[SCHEME_W-2:0], 1'b0};
              bit_next   = bit_reg + BIT_W'(1);
              cnt_next   = BIT_LOAD;
            end
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        S_WAIT_ACK: begin
          if (ack_hit) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            retry_next = '0;
          end else if (cnt_reg == '0) begin
            if (retry_reg == RTY_MAX) begin
              state_next = S_IDLE;
              retry_next = '0;
            end else begin
              retry_next = retry_reg + RTY_W'(1);
              if (slots == '0) begin
                state_next = S_HEAD;
                cnt_next   = HEAD_LOAD;
              end else begin
                state_next = S_BACKOFF;
                cnt_next   = backoff_load;
              end
            end
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    sending_next = (state_next == S_HEAD) || (state_next == S_DATA);
    head_next    = (state_next == S_HEAD);
    datacmd_next = (state_next == S_DATA) && shift_next[SCHEME_W-1];
    working_next = (state_next == S_IDLE) || (state_next == S_WAIT_ACK);
    done_next    = (state_reg == S_WAIT_ACK) && ack_hit && !stop_hit;
    fail_next    = (state_reg == S_WAIT_ACK) && !ack_hit && !stop_hit &&
                   (cnt_reg == '0) && (retry_reg == RTY_MAX);
  end

  // Output registers; listening is the idle default
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sending_reg <= 1'b0;
      head_reg    <= 1'b0;
      datacmd_reg <= 1'b0;
      working_reg <= 1'b1;
      done_reg    <= 1'b0;
      fail_reg    <= 1'b0;
    end else begin
      sending_reg <= sending_next;
      head_reg    <= head_next;
      datacmd_reg <= datacmd_next;
      working_reg <= working_next;
      done_reg    <= done_next;
      fail_reg    <= fail_next;
    end
  end

  assign sending   = sending_reg;
  assign head      = head_reg;
  assign datacmd   = datacmd_reg;
  assign working   = working_reg;
  assign done      = done_reg;
  assign fail      = fail_reg;
  assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: directed checks of mac_sched with small timing parameters.
// Cycle n is the clock period following edge n-1; inputs set during cycle n
// are sampled at edge n.
module tb_mac_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_valid = 1'b0;
  logic [1:0]  ord = 2'd0;
  logic [7:0]  cur_flag = 8'h00;
  logic [7:0]  cur_scheme = 8'h00;
  logic [23:0] cur_rand = 24'd0;
  logic        sending, head, datacmd, working, done, fail;
  logic [1:0]  retry_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mac_sched #(
    .SCHEME_W (8),
    .FLAG_W   (8),
    .MY_FLAG  (8'h01),
    .RAND_W   (24),
    .SLOT_W   (3),
    .SLOT_LEN (4),
    .HEAD_LEN (3),
    .BIT_LEN  (2),
    .ACK_TO   (10),
    .MAX_RETRY(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_valid(frame_valid),
    .ord        (ord),
    .cur_flag   (cur_flag),
    .cur_scheme (cur_scheme),
    .cur_rand   (cur_rand),
    .sending    (sending),
    .head       (head),
    .datacmd    (datacmd),
    .working    (working),
    .done       (done),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic advance(input int target);
    while (cyc < target) tick();
  endtask

  task automatic send(input logic [1:0] o, input logic [7:0] f, input logic [7:0] s);
    ord        = o;
    cur_flag   = f;
    cur_scheme = s;
    frame_valid = 1'b1;
    $display("txn cyc=%0d ord=%0d flag=%02h scheme=%02h rand=%0d", cyc, o, f, s, cur_rand);
    tick();
    frame_valid = 1'b0;
    ord         = 2'd0;
  endtask

  logic [7:0] sch;

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_working", 32'(working), 32'd1);
    chk("rst_sending", 32'(sending), 32'd0);
    chk("rst_head", 32'(head), 32'd0);
    chk("rst_datacmd", 32'(datacmd), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // Single frame: 1 slot backoff, A5 payload, ack in cycle 27
    sch = 8'hA5;
    cur_rand = 24'd1;
    cyc = 0;
    send(2'd1, 8'h01, sch);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("sf_bo_send_c%0d", c), 32'(sending), 32'd0);
      chk($sformatf("sf_bo_work_c%0d", c), 32'(working), 32'd0);
      tick();
    end
    for (int c = 5; c <= 7; c++) begin
      chk($sformatf("sf_head_c%0d", c), 32'(head), 32'd1);
      chk($sformatf("sf_hsend_c%0d", c), 32'(sending), 32'd1);
      tick();
    end
    for (int c = 8; c <= 23; c++) begin
      chk($sformatf("sf_dsend_c%0d", c), 32'(sending), 32'd1);
      chk($sformatf("sf_dhead_c%0d", c), 32'(head), 32'd0);
      chk($sformatf("sf_data_c%0d", c), 32'(datacmd), 32'(sch[7 - (c - 8) / 2]));
      tick();
    end
    chk("sf_wait_work", 32'(working), 32'd1);
    chk("sf_wait_send", 32'(sending), 32'd0);
    advance(27);
    send(2'd2, 8'h01, 8'h00);
    chk("sf_done", 32'(done), 32'd1);
    chk("sf_done_retry", 32'(retry_cnt), 32'd0);
    tick();
    chk("sf_done_pulse", 32'(done), 32'd0);
    chk("sf_idle_work", 32'(working), 32'd1);

    // Zero backoff with broadcast flag
    cur_rand = 24'd0;
    cyc = 0;
    send(2'd1, 8'hFF, 8'h3C);
    chk("zb_head", 32'(head), 32'd1);
    chk("zb_send", 32'(sending), 32'd1);
    send(2'd3, 8'h01, 8'h00);
    chk("zb_stop_send", 32'(sending), 32'd0);
    chk("zb_stop_head", 32'(head), 32'd0);
    chk("zb_stop_work", 32'(working), 32'd1);

    // Address filter: foreign flag and nop are ignored in IDLE
    cyc = 0;
    send(2'd1, 8'h02, 8'hFF);
    chk("af_send", 32'(sending), 32'd0);
    chk("af_work", 32'(working), 32'd1);
    send(2'd0, 8'h01, 8'hFF);
    advance(6);
    chk("af_send_late", 32'(sending), 32'd0);
    chk("af_head_late", 32'(head), 32'd0);

    // Retry growth: windows 1, 3, 7 slots then fail
    cur_rand = 24'h000007;
    cyc = 0;
    send(2'd1, 8'h01, 8'hC3);
    advance(33);
    chk("rg_w0_work", 32'(working), 32'd1);
    chk("rg_w0_retry", 32'(retry_cnt), 32'd0);
    tick();
    chk("rg_bo1_retry", 32'(retry_cnt), 32'd1);
    chk("rg_bo1_work", 32'(working), 32'd0);
    advance(45);
    chk("rg_bo1_end", 32'(sending), 32'd0);
    tick();
    chk("rg_head1", 32'(head), 32'd1);
    advance(74);
    chk("rg_w1_work", 32'(working), 32'd1);
    tick();
    chk("rg_bo2_retry", 32'(retry_cnt), 32'd2);
    chk("rg_bo2_work", 32'(working), 32'd0);
    advance(102);
    chk("rg_bo2_end", 32'(sending), 32'd0);
    tick();
    chk("rg_head2", 32'(head), 32'd1);
    advance(131);
    chk("rg_w2_fail", 32'(fail), 32'd0);
    tick();
    chk("rg_fail", 32'(fail), 32'd1);
    chk("rg_fail_retry", 32'(retry_cnt), 32'd0);
    chk("rg_fail_send", 32'(sending), 32'd0);
    chk("rg_fail_work", 32'(working), 32'd1);
    tick();
    chk("rg_fail_pulse", 32'(fail), 32'd0);

    // Stop during bit 3 of a zero-backoff frame
    cur_rand = 24'd0;
    cyc = 0;
    send(2'd1, 8'h01, 8'hFF);
    advance(10);
    chk("sp_bit3", 32'(datacmd), 32'd1);
    send(2'd3, 8'h01, 8'h00);
    chk("sp_send", 32'(sending), 32'd0);
    chk("sp_data", 32'(datacmd), 32'd0);
    chk("sp_work", 32'(working), 32'd1);
    chk("sp_retry", 32'(retry_cnt), 32'd0);

    // Fresh frame after stop; a query during DATA must not disturb it;
    // ack arrives in the final WAIT_ACK cycle
    sch = 8'h5A;
    cur_rand = 24'd1;
    cyc = 0;
    send(2'd1, 8'h01, sch);
    chk("fr_bo", 32'(working), 32'd0);
    advance(5);
    chk("fr_head", 32'(head), 32'd1);
    advance(8);
    chk("fr_bit0", 32'(datacmd), 32'(sch[7]));
    advance(11);
    send(2'd1, 8'h01, 8'h00);
    chk("ig_bit2", 32'(datacmd), 32'(sch[5]));
    chk("ig_send", 32'(sending), 32'd1);
    advance(14);
    chk("ig_bit3", 32'(datacmd), 32'(sch[4]));
    advance(22);
    chk("ig_bit7", 32'(datacmd), 32'(sch[0]));
    advance(33);
    chk("la_wait", 32'(working), 32'd1);
    send(2'd2, 8'hFF, 8'h00);
    chk("la_done", 32'(done), 32'd1);
    chk("la_nofail", 32'(fail), 32'd0);

    // Asynchronous reset during HEAD
    cur_rand = 24'd0;
    cyc = 0;
    send(2'd1, 8'h01, 8'hFF);
    chk("ar_head", 32'(head), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_send_async", 32'(sending), 32'd0);
    chk("ar_head_async", 32'(head), 32'd0);
    chk("ar_work_async", 32'(working), 32'd1);
    @(posedge clock);
    #1;
    chk("ar_send_hold", 32'(sending), 32'd0);
    chk("ar_head_hold", 32'(head), 32'd0);
    chk("ar_retry_hold", 32'(retry_cnt), 32'd0);
    reset = 1'b0;
    tick();
    chk("ar_post_send", 32'(sending), 32'd0);
    chk("ar_post_work", 32'(working), 32'd1);
    cyc = 0;
    send(2'd1, 8'h01, 8'h81);
    chk("ar_fresh_head", 32'(head), 32'd1);
    send(2'd3, 8'h01, 8'h00);
    chk("ar_fresh_stop", 32'(sending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
